parity_checker: RTL

Receive-side counterpart of the 32-bit even-parity generator: accepts a data word plus its transmitted parity bit over a valid/ready handshake, recomputes even parity, and forwards the word downstream with a per-word error flag after one register stage. It sits at the consumer end of any link protected by the generator. It also keeps a sticky error status and, optionally, a saturating error count for software.

---
 rtl/parity_pkg.sv | 14 +
 rtl/parity_xor.sv | 13 +
 rtl/parity_checker.sv | 129 ++++++++++++
 3 files changed

// File: rtl/parity_pkg.sv
// Shared constants for the even-parity generator/checker pair.
package parity_pkg;

   localparam int unsigned PAR_DATA_W = 32;

   // Expected XOR of all data bits together with the parity bit.
   localparam logic PAR_EVEN = 1'b0;

   typedef enum logic {
      ERR_OK  = 1'b0,
      ERR_SET = 1'b1
   } err_state_e;

endpackage

// File: rtl/parity_xor.sv
// Combinational XOR reduction of a data word; shared with the parity generator.
module parity_xor #(
   parameter int unsigned DATA_W = 32
) (
   input  logic [DATA_W-1:0] data,
   output logic              parity
);

   always_comb begin
      parity = ^data;
   end

endmodule

// File: rtl/parity_checker.sv
// Even-parity checker: one-stage valid/ready register with per-word error flag,
// sticky error status and, when PARITY_ERR_CNT_EN is defined, a saturating error counter.
module parity_checker
   import parity_pkg::*;
#(
   parameter int unsigned DATA_W = PAR_DATA_W
`ifdef PARITY_ERR_CNT_EN
   ,
   parameter int unsigned CNT_W  = 16
`endif
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_parity,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_err,
   input  logic              err_clr,
   output logic              err_sticky
`ifdef PARITY_ERR_CNT_EN
   ,
   output logic [CNT_W-1:0]  err_cnt
`endif
);

   logic              data_xor;
   logic              mismatch;
   logic              in_acc;
   logic              out_acc;
   logic              err_word;

   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_data_q,  out_data_d;
   logic              out_err_q,   out_err_d;
   err_state_e        err_state_q, err_state_d;

   parity_xor #(
      .DATA_W (DATA_W)
   ) u_parity_xor (
      .data   (in_data),
      .parity (data_xor)
   );

   always_comb begin
      mismatch = ((data_xor ^ in_parity) != PAR_EVEN);
      in_ready = !out_valid_q || out_ready;
      in_acc   = in_valid && in_ready;
      out_acc  = out_valid_q && out_ready;
      err_word = in_acc && mismatch;
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_err_d   = out_err_q;
      if (in_acc) begin
         out_valid_d = 1'b1;
         out_data_d  = in_data;
         out_err_d   = mismatch;
      end else if (out_acc) begin
         out_valid_d = 1'b0;
      end
   end

   // An erroneous word accepted alongside err_clr takes priority over the clear.
   always_comb begin
      err_state_d = err_state_q;
      unique case (err_state_q)
         ERR_OK: begin
            if (err_word) err_state_d = ERR_SET;
         end
         ERR_SET: begin
            if (err_clr && !err_word) err_state_d = ERR_OK;
         end
         default: err_state_d = ERR_OK;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_err_q   <= 1'b0;
         err_state_q <= ERR_OK;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_err_q   <= out_err_d;
         err_state_q <= err_state_d;
      end
   end

   always_comb begin
      out_valid  = out_valid_q;
      out_data   = out_data_q;
      out_err    = out_err_q;
      err_sticky = (err_state_q == ERR_SET);
   end

`ifdef PARITY_ERR_CNT_EN
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

   always_comb begin
      err_cnt_d = err_cnt_q;
      if (err_clr) begin
         err_cnt_d = err_word ? CNT_W'(1) : '0;
      end else if (err_word && (err_cnt_q != {CNT_W{1'b1}})) begin
         err_cnt_d = err_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt_q <= '0;
      end else begin
         err_cnt_q <= err_cnt_d;
      end
   end

   always_comb begin
      err_cnt = err_cnt_q;
   end
`endif

endmodule
